mem_responder: RTL and testbench
================================

# mem_responder

Serial memory responder: the far end of the CPU's 2-bit-per-cycle TX/RX memory link. Receives command frames on `rx_pins` (driven by the CPU's transmit side), performs byte or 16-bit little-endian reads/writes on an internal byte-addressed RAM, and returns read data as reply frames on `tx_pins` (sampled by the CPU's receive side). Used as the on-chip or bench-side memory model behind the decoder/scheduler's transaction interface.

## Interface
- `NSHIFT`, 2: bits per link cycle; the block supports only 2.
- `MEM_BITS`, 8: RAM address width; RAM holds 2^MEM_BITS bytes.
- `REPLY_DELAY`, 2: idle cycles between the last address symbol and the reply start symbol; legal range 0..15.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_pins` in NSHIFT: command/address/write-data symbols from the CPU.
- `tx_pins` out NSHIFT: reply symbols to the CPU; 2'b00 when idle.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky error flag; cleared only by `reset`.
- `frame_done` out 1: one-cycle pulse on the last cycle of each accepted frame (last write-data symbol, or last reply symbol).

## Operation
- States: IDLE, CMD, ADDR, WDATA, WAIT, REPLY. A 3-bit symbol counter and a 4-bit delay counter.
- IDLE: `rx_pins[0]==1` is a start symbol (`rx_pins[1]` ignored) -> CMD. Otherwise stay.
- CMD: latch `cmd = rx_pins`; `cmd[0]` = write, `cmd[1]` = wide (16-bit) -> ADDR.
- ADDR: 8 symbols, 16-bit address LSB-first (symbol k = addr[2k+1:2k]). Only addr[MEM_BITS-1:0] is used; upper bits ignored. After the 8th: write -> WDATA, read -> WAIT (or directly REPLY if REPLY_DELAY=0).
- WDATA: 4 symbols (byte) or 8 symbols (wide), LSB-first. On the edge ending the last symbol: RAM[a] <= data[7:0]; if wide also RAM[(a+1) mod 2^MEM_BITS] <= data[15:8]. Then IDLE. No reply for writes.
- WAIT: REPLY_DELAY cycles with `tx_pins`=00, then REPLY.
- REPLY: cycle 0 drives start symbol 2'b01; read data captured from RAM in this cycle (low byte RAM[a], high byte RAM[(a+1) mod 2^MEM_BITS]); then 4 (byte) or 8 (wide) data symbols LSB-first; then IDLE with `tx_pins`=00.
- Overrun: in WAIT or REPLY, any nonzero `rx_pins` sets `overrun`; those symbols are dropped, the current reply completes unchanged.
- RAM contents are not affected by reset and are undefined until written.

## Timing
- Reset values: state IDLE, `tx_pins`=00, `busy`=0, `overrun`=0, `frame_done`=0, counters 0.
- Start symbol at cycle t: cmd at t+1, address t+2..t+9.
- Byte write: data t+10..t+13, RAM updated at end of t+13, `frame_done` at t+13, next start accepted at t+14. Wide write: data t+10..t+17, next start at t+18.
- Read: reply start symbol at t+10+REPLY_DELAY, data follows immediately; byte read last symbol at t+14+D, wide at t+18+D; `frame_done` on last symbol; next start accepted the following cycle.
- A write completing at cycle n is visible to any later read (reply start always follows address phase by at least 1 cycle).
- `busy` rises the cycle after the start symbol and falls the cycle after `frame_done`.
- Reset in any state (including the last WDATA cycle): returns to IDLE next cycle; the pending write is suppressed; no partial reply continues.
- Address wrap: wide access at addr 2^MEM_BITS-1 touches bytes 2^MEM_BITS-1 and 0.

## Test plan
- Byte write 0x5A to 0x0012 (symbols: 1, 1, 2,0,1,0,0,0,0,0, 2,2,1,1), then byte read 0x0012 with D=2 -> `tx_pins` 00,00 then 01, 2,2,1,1, then 00; `frame_done` on last symbol.
- Wide write 0xBEEF to 0x00FF with MEM_BITS=8 -> RAM[0xFF]=0xEF, RAM[0x00]=0xBE; wide read 0x00FF returns symbols 3,3,2,3,2,3,3,2.
- REPLY_DELAY=0: read start symbol at t+10 exactly; address bits 15:8 = 0xA5 vs 0x00 return identical data.
- Overrun: drive `rx_pins`=01 during WAIT -> `overrun`=1 sticky, reply data unchanged, symbol not treated as a new frame; `reset` clears it.
- Reset asserted on last WDATA cycle of byte write 0x77 to 0x0020 (prior value 0x11) -> subsequent read returns 0x11; outputs at reset values.
- Back-to-back: write frame then start symbol on the very next cycle after `frame_done` -> accepted, no `overrun`, correct reply.

Source files
------------

// File: rtl/mem_responder.sv
// Far end of the 2-bit serial memory link: decodes command frames on rx_pins,
// services byte/16-bit little-endian accesses to an internal RAM, and replies on tx_pins.
module mem_responder #(
  parameter int NSHIFT      = 2,
  parameter int MEM_BITS    = 8,
  parameter int REPLY_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSHIFT-1:0] rx_pins,
  output logic [NSHIFT-1:0] tx_pins,
  output logic              busy,
  output logic              overrun,
  output logic              frame_done
);

  localparam int DEPTH = 1 << MEM_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_REPLY
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            dly_q, dly_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [MEM_BITS-1:0]   addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  hdr_q, hdr_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            ram_q [DEPTH];

  logic [MEM_BITS-1:0]   addr_p1;
  logic                  last_sym;
  logic                  ram_we;

  assign addr_p1  = addr_q + MEM_BITS'(1);
  assign last_sym = cmd_q[1] ? (cnt_q == 3'd7) : (cnt_q == 3'd3);
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hdr_d      = hdr_q;
    overrun_d  = overrun_q;
    ram_we     = 1'b0;
    tx_pins    = 2'b00;
    frame_done = 1'b0;

    // Traffic while a reply is pending is flagged and otherwise ignored.
    if ((state_q == S_WAIT || state_q == S_REPLY) && rx_pins != 2'b00) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_pins[0]) begin
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        cmd_d   = rx_pins;
        cnt_d   = 3'd0;
        state_d = S_ADDR;
      end

      S_ADDR: begin
        // Symbol k carries addr[2k+1:2k]; bits beyond the RAM width are dropped.
        for (int i = 0; i < MEM_BITS; i++) begin
          if ((i / 2) == int'(cnt_q)) begin
            addr_d[i] = (i % 2 == 0) ? rx_pins[0] : rx_pins[1];
          end
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d = 3'd0;
          if (cmd_q[0]) begin
            state_d = S_WDATA;
          end else if (REPLY_DELAY == 0) begin
            state_d = S_REPLY;
            hdr_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            dly_d   = 4'd0;
          end
        end
      end

      S_WDATA: begin
        wdata_d[{cnt_q, 1'b0} +: 2] = rx_pins;
        cnt_d = cnt_q + 3'd1;
        if (last_sym) begin
          ram_we     = 1'b1;
          frame_done = 1'b1;
          cnt_d      = 3'd0;
          state_d    = S_IDLE;
        end
      end

      S_WAIT: begin
        dly_d = dly_q + 4'd1;
        if (dly_q == 4'(REPLY_DELAY - 1)) begin
          dly_d   = 4'd0;
          state_d = S_REPLY;
          hdr_d   = 1'b1;
        end
      end

      S_REPLY: begin
        if (hdr_q) begin
          // Data is sampled as the start symbol goes out, so a write that just
          // finished is always visible here.
          tx_pins = 2'b01;
          rdata_d = {ram_q[addr_p1], ram_q[addr_q]};
          hdr_d   = 1'b0;
          cnt_d   = 3'd0;
        end else begin
          tx_pins = rdata_q[{cnt_q, 1'b0} +: 2];
          cnt_d   = cnt_q + 3'd1;
          if (last_sym) begin
            frame_done = 1'b1;
            cnt_d      = 3'd0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      dly_q     <= 4'd0;
      cmd_q     <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      hdr_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hdr_q     <= hdr_d;
      overrun_q <= overrun_d;
    end
  end

  // RAM keeps its contents across reset; reset only cancels an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram_q[addr_q] <= wdata_d[7:0];
      if (cmd_q[1]) begin
        ram_q[addr_p1] <= wdata_d[15:8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with REPLY_DELAY=2, one with 0.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx_a, rx_b, tx_a, tx_b;
  logic       busy_a, busy_b, ovr_a, ovr_b, fd_a, fd_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.NSHIFT(2), .MEM_BITS(8), .REPLY_DELAY(2)) u_dut (
    .clk(clk), .reset(reset), .rx_pins(rx_a), .tx_pins(tx_a),
    .busy(busy_a), .overrun(ovr_a), .frame_done(fd_a)
  );

  mem_responder #(.NSHIFT(2), .MEM_BITS(8), .REPLY_DELAY(0)) u_dut0 (
    .clk(clk), .reset(reset), .rx_pins(rx_b), .tx_pins(tx_b),
    .busy(busy_b), .overrun(ovr_b), .frame_done(fd_b)
  );

  typedef struct packed {
    logic        wide;
    logic [15:0] data;
    logic [31:0] start;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        cur[2];
  logic        act[2];
  int          idx[2];
  logic [15:0] got[2];
  logic        s_fd, s_busy;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic mon_step(input int w, input logic [1:0] tx, input logic fd);
    int n;
    if (!act[w]) begin
      if (tx == 2'b01) begin
        if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_reply dut%0d @cyc %0d: got reply, expected none", w, cyc);
        end else begin
          if (w == 0) cur[w] = q_a.pop_front();
          else        cur[w] = q_b.pop_front();
          chk("reply_start_cycle", cyc, cur[w].start);
          act[w] = 1'b1;
          idx[w] = 0;
          got[w] = 16'h0000;
        end
      end else begin
        chk("idle_tx", {30'd0, tx}, 32'd0);
      end
    end else begin
      n = cur[w].wide ? 8 : 4;
      got[w][idx[w]*2 +: 2] = tx;
      chk("reply_frame_done", {31'd0, fd}, {31'd0, (idx[w] == n - 1)});
      idx[w]++;
      if (idx[w] == n) begin
        act[w] = 1'b0;
        if (cur[w].wide) chk("reply_data16", {16'd0, got[w]}, {16'd0, cur[w].data});
        else             chk("reply_data8", {24'd0, got[w][7:0]}, {24'd0, cur[w].data[7:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_step(0, tx_a, fd_a);
      mon_step(1, tx_b, fd_b);
    end
  end

  // Present one symbol for one cycle; outputs are sampled mid-cycle.
  task automatic drive(input int w, input logic [1:0] v);
    if (w == 0) rx_a = v; else rx_b = v;
    @(negedge clk);
    s_fd   = (w == 0) ? fd_a : fd_b;
    s_busy = (w == 0) ? busy_a : busy_b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int w, input logic wr, input logic wide,
                            input logic [15:0] addr, input logic [15:0] data,
                            input logic ovr);
    int   t;
    int   d;
    int   n;
    exp_t e;
    d = (w == 0) ? 2 : 0;
    n = wide ? 8 : 4;
    t = cyc;
    drive(w, 2'b01);
    chk("busy_on_start", {31'd0, s_busy}, 32'd0);
    drive(w, {wide, wr});
    chk("busy_after_start", {31'd0, s_busy}, 32'd1);
    for (int k = 0; k < 8; k++) drive(w, addr[2*k +: 2]);
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        drive(w, data[2*k +: 2]);
        chk("write_frame_done", {31'd0, s_fd}, {31'd0, (k == n - 1)});
      end
    end else begin
      e.wide  = wide;
      e.data  = data;
      e.start = 32'(t + 10 + d);
      if (w == 0) q_a.push_back(e); else q_b.push_back(e);
      for (int k = 0; k < d + n + 1; k++) drive(w, (ovr && k == 0) ? 2'b01 : 2'b00);
    end
    if (w == 0) rx_a = 2'b00; else rx_b = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      idx[i] = 0;
      got[i] = 16'h0000;
    end
    reset = 1'b1;
    rx_a  = 2'b00;
    rx_b  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {30'd0, tx_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_overrun", {31'd0, ovr_a}, 32'd0);
    chk("rst_frame_done", {31'd0, fd_a}, 32'd0);
    chk("rst_busy_d0", {31'd0, busy_b}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Byte write then back-to-back byte read
    send_frame(0, 1'b1, 1'b0, 16'h0012, 16'h005A, 1'b0);
    send_frame(0, 1'b0, 1'b0, 16'h0012, 16'h005A, 1'b0);

    // Wide write across the top of the address space
    send_frame(0, 1'b1, 1'b1, 16'h00FF, 16'hBEEF, 1'b0);
    send_frame(0, 1'b0, 1'b1, 16'h00FF, 16'hBEEF, 1'b0);
    send_frame(0, 1'b0, 1'b0, 16'h0000, 16'h00BE, 1'b0);
    send_frame(0, 1'b0, 1'b0, 16'h00FF, 16'h00EF, 1'b0);

    // Zero reply delay; upper address byte must not matter
    send_frame(1, 1'b1, 1'b0, 16'h0040, 16'h003C, 1'b0);
    send_frame(1, 1'b0, 1'b0, 16'h0040, 16'h003C, 1'b0);
    send_frame(1, 1'b0, 1'b0, 16'hA540, 16'h003C, 1'b0);
    @(negedge clk);
    chk("no_overrun_b2b", {31'd0, ovr_a}, 32'd0);
    chk("no_overrun_b2b_d0", {31'd0, ovr_b}, 32'd0);
    @(posedge clk);
    #1;

    // Overrun: stray start symbol during WAIT
    send_frame(0, 1'b1, 1'b0, 16'h0020, 16'h0011, 1'b0);
    send_frame(0, 1'b0, 1'b0, 16'h0020, 16'h0011, 1'b1);
    @(negedge clk);
    chk("overrun_set", {31'd0, ovr_a}, 32'd1);
    chk("overrun_no_new_frame", {31'd0, busy_a}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("overrun_sticky", {31'd0, ovr_a}, 32'd1);
    @(posedge clk);
    #1;

    // Reset on the last WDATA cycle of a byte write of 0x77 to 0x0020
    drive(0, 2'b01);
    drive(0, 2'b01);
    for (int k = 0; k < 8; k++) drive(0, (k == 2) ? 2'b10 : 2'b00);
    drive(0, 2'b11);
    drive(0, 2'b01);
    drive(0, 2'b11);
    rx_a  = 2'b01;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_a  = 2'b00;
    @(negedge clk);
    chk("mid_rst_tx", {30'd0, tx_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_overrun", {31'd0, ovr_a}, 32'd0);
    chk("mid_rst_frame_done", {31'd0, fd_a}, 32'd0);
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, 1'b0, 16'h0020, 16'h0011, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("replies_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    chk("monitor_idle", {31'd0, (act[0] | act[1])}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
